// File: rtl/nixie_pkg.sv
// Shared constants and segment decode helper for the nixie scan counter.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; dp is always off.
package nixie_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_LUT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] s;
        s = SEG_BLANK;
        case (nib)
            4'd0: s = SEG_LUT[0];
            4'd1: s = SEG_LUT[1];
            4'd2: s = SEG_LUT[2];
            4'd3: s = SEG_LUT[3];
            4'd4: s = SEG_LUT[4];
            4'd5: s = SEG_LUT[5];
            4'd6: s = SEG_LUT[6];
            4'd7: s = SEG_LUT[7];
            4'd8: s = SEG_LUT[8];
            4'd9: s = SEG_LUT[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/nixie_scan_counter_seg_decode.sv
// Combinational BCD nibble to active-low 7-seg code; non-BCD shows blank.
// Ports: bcd_i (4b digit), seg_o (8b {dp,g,f,e,d,c,b,a}, active-low).
module nixie_seg_decode
    import nixie_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    assign seg_o = seg_decode(bcd_i);

endmodule

// File: rtl/nixie_scan_counter.sv
// N-digit BCD up/down counter with multiplexed common-anode 7-seg scan.
// Ports: sys_clk, sys_rst (sync, active-high), en, up_dn, clr in;
//   count_bcd (4*DIGITS, digit 0 in [3:0]), wrap pulse, seg (active-low),
//   sel (one-hot active-low) out.
// Option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module nixie_scan_counter
    import nixie_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     sel
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         presc_q, presc_d;
    logic [4*DIGITS-1:0]   cnt_q, cnt_d;
    logic                  wrap_q, wrap_d;
    logic [SW-1:0]         scan_q, scan_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic                  tick;
    logic                  carry;
    logic [3:0]            dig;
    logic [3:0]            cur_nib;
    logic [7:0]            dec_seg;

    assign tick = en && (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Carry/borrow ripples through all digits in one cycle; a carry
    // out of the top digit is the wrap condition.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        carry  = 1'b1;
        dig    = 4'd0;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig = cnt_q[4*i +: 4];
                if (carry) begin
                    if (up_dn) begin
                        if (dig == 4'd9) begin
                            dig = 4'd0;
                        end else begin
                            dig   = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            dig = 4'd9;
                        end else begin
                            dig   = dig - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
                cnt_d[4*i +: 4] = dig;
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // seg and sel both follow the next scan index so they change together.
    assign sel_d   = ~(DIGITS'(1) << idx_d);
    assign cur_nib = cnt_q[{idx_d, 2'b00} +: 4];

    nixie_seg_decode u_dec (
        .bcd_i (cur_nib),
        .seg_o (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic blank;
    logic hi_zero;

    // Blank digit i>0 when it and every higher digit are zero.
    always_comb begin
        blank   = 1'b0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero = hi_zero && (cnt_q[4*i +: 4] == 4'd0);
            if ((IW'(i) == idx_d) && hi_zero) begin
                blank = 1'b1;
            end
        end
    end

    assign seg_d = blank ? SEG_BLANK : dec_seg;
`else
    assign seg_d = dec_seg;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            sel_q   <= ~DIGITS'(1);
            seg_q   <= SEG_LUT[0];
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign count_bcd = cnt_q;
    assign wrap      = wrap_q;
    assign seg       = seg_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_nixie_scan_counter.sv
// Self-checking bench for nixie_scan_counter (DIGITS=2, TICK_DIV=4, SCAN_DIV=2).
// Integer-valued reference model plus directed literal checks and random traffic.
module tb_nixie_scan_counter;

    localparam int D    = 2;
    localparam int TDIV = 4;
    localparam int SDIV = 2;
    localparam int MOD  = 100;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           up = 1'b1;
    logic           clr = 1'b0;
    logic [4*D-1:0] count_bcd;
    logic           wrap;
    logic [7:0]     seg;
    logic [D-1:0]   sel;

    int n_chk  = 0;
    int n_pass = 0;

    nixie_scan_counter #(
        .DIGITS   (D),
        .TICK_DIV (TDIV),
        .SCAN_DIV (SDIV)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .en        (en),
        .up_dn     (up),
        .clr       (clr),
        .count_bcd (count_bcd),
        .wrap      (wrap),
        .seg       (seg),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    logic [7:0] lut [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        r = '0;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    // Reference model: count as a plain integer modulo 10^D.
    int             m_val, m_pre, m_scan, m_idx;
    logic           m_wrap;
    logic [7:0]     m_seg;
    logic [D-1:0]   m_sel;
    bit             chk_on = 1'b0;

    always @(posedge clk) begin
        int old_val;
        int hi;
        old_val = m_val;
        if (rst) begin
            m_val = 0; m_pre = 0; m_scan = 0; m_idx = 0;
            m_wrap = 1'b0; m_seg = 8'hC0; m_sel = ~D'(1);
            chk_on = 1'b1;
        end else begin
            if (m_scan == SDIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % D;
            end else begin
                m_scan++;
            end
            m_sel = ~(D'(1) << m_idx);
            hi    = old_val / pow10(m_idx);
            if (BLANK && m_idx > 0 && hi == 0) m_seg = 8'hFF;
            else m_seg = lut[hi % 10];
            m_wrap = 1'b0;
            if (clr) begin
                m_val = 0;
                m_pre = 0;
            end else if (en) begin
                if (m_pre == TDIV - 1) begin
                    m_pre = 0;
                    if (up) begin
                        m_wrap = (m_val == MOD - 1);
                        m_val  = (m_val + 1) % MOD;
                    end else begin
                        m_wrap = (m_val == 0);
                        m_val  = (m_val + MOD - 1) % MOD;
                    end
                end else begin
                    m_pre++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_count", 32'(count_bcd), 32'(to_bcd(m_val)));
            chk("model_wrap", 32'(wrap), 32'(m_wrap));
            chk("model_sel", 32'(sel), 32'(m_sel));
            chk("model_seg", 32'(seg), 32'(m_seg));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit found;
        // 1: reset
        cyc(2);
        chk("rst_count", 32'(count_bcd), 32'h00);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_sel", 32'(sel), 32'h2);
        chk("rst_seg", 32'(seg), 32'hC0);
        rst = 1'b0;
        cyc(3);
        chk("hold_count", 32'(count_bcd), 32'h00);
        chk("hold_wrap", 32'(wrap), 32'h0);

        // 2: ten ticks up, then hold with en=0
        en = 1'b1; up = 1'b1;
        cyc(40);
        chk("ten_ticks", 32'(count_bcd), 32'h10);
        en = 1'b0;
        cyc(20);
        chk("en_hold", 32'(count_bcd), 32'h10);

        // 3: up to 99 then wrap to 00
        en = 1'b1;
        cyc(356);
        chk("reach_99", 32'(count_bcd), 32'h99);
        cyc(4);
        chk("wrap_up_cnt", 32'(count_bcd), 32'h00);
        chk("wrap_up_pulse", 32'(wrap), 32'h1);
        cyc(1);
        chk("wrap_up_drop", 32'(wrap), 32'h0);

        // 4: down from 00 (prescaler is at 1 here)
        up = 1'b0;
        cyc(3);
        chk("wrap_dn_cnt", 32'(count_bcd), 32'h99);
        chk("wrap_dn_pulse", 32'(wrap), 32'h1);
        cyc(4);
        chk("dn_98", 32'(count_bcd), 32'h98);
        chk("dn_98_wrap", 32'(wrap), 32'h0);

        // 5: clear coinciding with a tick at 42
        clr = 1'b1; up = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(168);
        chk("reach_42", 32'(count_bcd), 32'h42);
        cyc(3);
        clr = 1'b1;
        cyc(1);
        chk("clr_cnt", 32'(count_bcd), 32'h00);
        chk("clr_wrap", 32'(wrap), 32'h0);
        clr = 1'b0;
        cyc(3);
        chk("clr_no_tick", 32'(count_bcd), 32'h00);
        cyc(1);
        chk("clr_first_tick", 32'(count_bcd), 32'h01);

        // 6: scan of 07
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(28);
        en = 1'b0;
        cyc(2);
        chk("cnt_07", 32'(count_bcd), 32'h07);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (sel == 2'b10) chk("scan_d0", 32'(seg), 32'hF8);
            else chk("scan_d1", 32'(seg), BLANK ? 32'hFF : 32'hC0);
        end
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            cyc(1);
            if (sel == 2'b01) found = 1'b1;
        end
        chk("scan_found_d1", 32'(found), 32'h1);
        rst = 1'b1;
        cyc(1);
        chk("midscan_sel", 32'(sel), 32'h2);
        chk("midscan_seg", 32'(seg), 32'hC0);
        chk("midscan_cnt", 32'(count_bcd), 32'h00);
        rst = 1'b0;

        // random traffic, checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            en  = ($urandom_range(0, 9) < 8);
            up  = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst = 1'b0; clr = 1'b0; en = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
